// File: rtl/app_test_pkg.sv
// Shared types, width helpers and LFSR constants for the app stream tester.
package app_test_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Tap mask for x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic int pw_of(input int bits);
        return 32'd1 << bits;
    endfunction

    function automatic int lanes_of(input int bits);
        return 32'd64 >> bits;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = ^(s & LFSR_TAPS);
        return {fb, s[15:1]};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_tester_pattern.sv
// Combinational test-word generator: lane j of word k is (k*LANES + j + incr) mod 2^PW.
module stream_tester_pattern
    import app_test_pkg::*;
#(
    parameter int BITS = 3
) (
    input  logic [15:0] word_idx,
    input  logic        incr,
    output logic [63:0] word
);

    localparam int PW    = pw_of(BITS);
    localparam int LANES = lanes_of(BITS);
    localparam int SHIFT = 6 - BITS;

    // Each lane wraps on its own; truncating to PW bits keeps carries out of the next lane
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign word[j*PW +: PW] = PW'({48'd0, word_idx} << SHIFT) + PW'(j) + PW'(incr);
    end

endmodule

// File: rtl/app_stream_tester.sv
// Source/sink tester for the app 64-bit word stream: sends NWORDS pattern words, checks the +1 echo.
// Optional STREAM_TESTER_STALL_EN adds LFSR-driven rx backpressure.
module app_stream_tester
    import app_test_pkg::*;
#(
    parameter int BITS    = 3,
    parameter int NWORDS  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timed_out,
    output logic [15:0] err_count,
    output logic [63:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [63:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int            IW        = $clog2(TIMEOUT + 1);
    localparam logic [15:0]   NWORDS_W  = 16'(NWORDS);
    localparam logic [IW-1:0] TIMEOUT_W = IW'(TIMEOUT);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [15:0]   tx_cnt_r;
    logic [15:0]   rx_cnt_r;
    logic [15:0]   err_count_r;
    logic [IW-1:0] idle_cnt_r;
    logic [63:0]   tx_data_r;
    logic          tx_valid_r;
    logic          rx_ready_r;
    logic          busy_r;
    logic          done_r;
    logic          pass_r;
    logic          timed_out_r;

    logic          tx_hs_s;
    logic          rx_hs_s;
    logic          mismatch_s;
    logic          enter_run_s;
    logic          timeout_hit_s;
    logic          run_ready_s;
    logic [15:0]   tx_cnt_nxt_s;
    logic [15:0]   rx_cnt_nxt_s;
    logic [15:0]   err_nxt_s;
    logic [IW-1:0] idle_nxt_s;
    logic [63:0]   tx_pat_s;
    logic [63:0]   exp_word_s;

    stream_tester_pattern #(.BITS(BITS)) u_tx_pat (
        .word_idx (tx_cnt_nxt_s),
        .incr     (1'b0),
        .word     (tx_pat_s)
    );

    stream_tester_pattern #(.BITS(BITS)) u_exp_pat (
        .word_idx (rx_cnt_r),
        .incr     (1'b1),
        .word     (exp_word_s)
    );

    assign tx_hs_s      = tx_valid_r & tx_ready;
    assign rx_hs_s      = rx_ready_r & rx_valid;
    assign mismatch_s   = rx_hs_s & (rx_data != exp_word_s);
    assign rx_cnt_nxt_s = rx_cnt_r + {15'd0, rx_hs_s};
    assign err_nxt_s    = mismatch_s ? sat_inc16(err_count_r) : err_count_r;
    assign idle_nxt_s   = rx_hs_s ? {IW{1'b0}} : (idle_cnt_r + IW'(1));
    // Index 0 is preloaded on the start edge so tx_valid rises with the first word already in place
    assign tx_cnt_nxt_s = enter_run_s ? 16'd0 : (tx_cnt_r + {15'd0, tx_hs_s});

`ifdef STREAM_TESTER_STALL_EN
    logic [15:0] lfsr_r;
    logic [15:0] lfsr_nxt_s;

    assign lfsr_nxt_s  = enter_run_s ? LFSR_SEED : lfsr_step(lfsr_r);
    assign run_ready_s = ~lfsr_nxt_s[0];

    // Backpressure LFSR: reseeded on run entry, advanced once per RUN cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_r <= LFSR_SEED;
        end else if (enter_run_s || (state_r == RUN)) begin
            lfsr_r <= lfsr_nxt_s;
        end
    end
`else
    assign run_ready_s = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; completion wins over timeout since an rx handshake clears the idle count
    always_comb begin
        state_nxt_s   = state_r;
        enter_run_s   = 1'b0;
        timeout_hit_s = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt_s = RUN;
                    enter_run_s = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            RUN: begin
                if (rx_cnt_nxt_s == NWORDS_W) begin
                    state_nxt_s = DONE;
                end else if (idle_nxt_s == TIMEOUT_W) begin
                    state_nxt_s   = DONE;
                    timeout_hit_s = 1'b1;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Counters, stream handshake registers and status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_cnt_r    <= 16'd0;
            rx_cnt_r    <= 16'd0;
            err_count_r <= 16'd0;
            idle_cnt_r  <= {IW{1'b0}};
            tx_data_r   <= 64'd0;
            tx_valid_r  <= 1'b0;
            rx_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            timed_out_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (enter_run_s) begin
                        tx_cnt_r    <= 16'd0;
                        rx_cnt_r    <= 16'd0;
                        err_count_r <= 16'd0;
                        idle_cnt_r  <= {IW{1'b0}};
                        tx_data_r   <= tx_pat_s;
                        tx_valid_r  <= 1'b1;
                        rx_ready_r  <= run_ready_s;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        pass_r      <= 1'b0;
                        timed_out_r <= 1'b0;
                    end
                end
                RUN: begin
                    tx_cnt_r    <= tx_cnt_nxt_s;
                    rx_cnt_r    <= rx_cnt_nxt_s;
                    idle_cnt_r  <= idle_nxt_s;
                    err_count_r <= err_nxt_s;
                    if (state_nxt_s != RUN) begin
                        tx_valid_r  <= 1'b0;
                        rx_ready_r  <= 1'b0;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        timed_out_r <= timeout_hit_s;
                        pass_r      <= (err_nxt_s == 16'd0) && !timeout_hit_s;
                    end else begin
                        rx_ready_r <= run_ready_s;
                        if (tx_hs_s) begin
                            if (tx_cnt_nxt_s == NWORDS_W) begin
                                tx_valid_r <= 1'b0;
                            end else begin
                                tx_data_r <= tx_pat_s;
                            end
                        end
                    end
                end
                default: begin
                    tx_valid_r <= 1'b0;
                    rx_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign timed_out = timed_out_r;
    assign err_count = err_count_r;
    assign tx_data   = tx_data_r;
    assign tx_valid  = tx_valid_r;
    assign rx_ready  = rx_ready_r;

endmodule
